// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and keeps at most one request outstanding to instruction
// memory. It presents the fetched word (or an all-zero bubble) to the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        jmp,
  input  logic        jr,
  input  logic        beq,
  input  logic [31:0] jmpTarget,
  input  logic [31:0] jrTarget,
  input  logic [31:0] beqTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCplusF,
  output logic        validF
);

  typedef enum logic [1:0] {StIssue, StWait, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;

  logic        redir;
  logic        consume;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_addr = pc_q;

  always_comb begin
    redir        = (jr | jmp | beq) & ~stallF;
    redir_target = jr ? jrTarget : (jmp ? jmpTarget : beqTarget);
  end

  // Outputs are forced to a bubble while reset is held, whatever the state.
  always_comb begin
    imem_req = 1'b0;
    validF   = 1'b0;
    instrF   = '0;
    PCplusF  = '0;
    if (!reset) begin
      case (state_q)
        StIssue: imem_req = 1'b1;
        StWait: begin
          if (imem_rvalid) begin
            validF = 1'b1;
            instrF = imem_rdata;
          end
        end
        StHold: begin
          validF = 1'b1;
          instrF = buf_q;
        end
        default: ;
      endcase
      if (validF) PCplusF = pc_plus4;
    end
  end

  assign consume = validF & ~stallF;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      state_q <= StIssue;
    end else begin
      case (state_q)
        StIssue: begin
          // The request already went out this cycle, so a redirect must still drain it.
          if (redir) begin
            pc_q    <= redir_target;
            state_q <= StDrain;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_rvalid) begin
            if (redir) begin
              pc_q    <= redir_target;
              state_q <= StIssue;
            end else if (consume) begin
              pc_q    <= pc_plus4;
              state_q <= StIssue;
            end else begin
              buf_q   <= imem_rdata;
              state_q <= StHold;
            end
          end else if (redir) begin
            pc_q    <= redir_target;
            state_q <= StDrain;
          end
        end
        StHold: begin
          if (redir) begin
            pc_q    <= redir_target;
            state_q <= StIssue;
          end else if (consume) begin
            pc_q    <= pc_plus4;
            state_q <= StIssue;
          end
        end
        StDrain: begin
          if (redir) pc_q <= redir_target;
          if (imem_rvalid) state_q <= StIssue;
        end
        default: state_q <= StIssue;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small latency-configurable memory model plus scoreboard queues
// of expected request addresses and expected presented instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, jmp, jr, beq;
  logic [31:0] jmpTarget, jrTarget, beqTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instrF, PCplusF;
  logic        validF;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .jmp        (jmp),
    .jr         (jr),
    .beq        (beq),
    .jmpTarget  (jmpTarget),
    .jrTarget   (jrTarget),
    .beqTarget  (beqTarget),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instrF     (instrF),
    .PCplusF    (PCplusF),
    .validF     (validF)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] req_q[$];
  logic [31:0] out_q[$];

  // Memory model state
  int          lat;
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;

  // Values sampled in the most recent cycle
  logic        s_req, s_valid;
  logic [31:0] s_instr, s_pcplus;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample at the falling edge, score, advance.
  task automatic tick();
    if (reset) begin
      pend        = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end else if (pend && pend_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend_addr);
      pend        = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) pend_cnt--;
    end
    #4;
    s_req    = imem_req;
    s_valid  = validF;
    s_instr  = instrF;
    s_pcplus = PCplusF;
    if (imem_req) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      if (req_q.size() == 0) chk("unexpected_req", 32'(imem_req), 32'd0);
      else chk("req_addr", imem_addr, req_q.pop_front());
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = lat - 1;
    end
    if (validF) begin
      if (out_q.size() == 0) chk("unexpected_valid", 32'(validF), 32'd0);
      else begin
        chk("instrF", instrF, word(out_q[0]));
        chk("PCplusF", PCplusF, out_q[0] + 32'd4);
        if (!stallF) void'(out_q.pop_front());
      end
    end else begin
      chk("bubble_instr", instrF, 32'd0);
      chk("bubble_pcplus", PCplusF, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stallF = 1'b0; jmp = 1'b0; jr = 1'b0; beq = 1'b0;
    jmpTarget = '0; jrTarget = '0; beqTarget = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
    @(posedge clk);
    #1;

    // Reset state
    tick();
    tick();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_valid), 32'd0);

    // Straight-line fetch, 1-cycle memory
    for (int i = 0; i < 3; i++) begin
      req_q.push_back(32'h3000 + 32'(4 * i));
      out_q.push_back(32'h3000 + 32'(4 * i));
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("seq_req", 32'(s_req), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("seq_valid", 32'(s_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    reset = 1'b1;
    tick();
    tick();

    // Stall while 0x3004's response is presented
    reset = 1'b0;
    req_q.push_back(32'h3000); out_q.push_back(32'h3000);
    req_q.push_back(32'h3004); out_q.push_back(32'h3004);
    tick();
    tick();
    tick();
    chk("stall_pre_req", 32'(s_req), 32'd1);
    stallF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", 32'(s_req), 32'd0);
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_pcplus", s_pcplus, 32'h3008);
    end
    stallF = 1'b0;
    req_q.push_back(32'h3008);
    tick();
    chk("release_req", 32'(s_req), 32'd0);
    tick();
    chk("req_after_stall", 32'(s_req), 32'd1);

    // Stalled redirect: jmp ignored while stallF=1
    out_q.push_back(32'h3008);
    stallF = 1'b1; jmp = 1'b1; jmpTarget = 32'h7000;
    tick();
    tick();
    chk("stalled_jmp_valid", 32'(s_valid), 32'd1);
    chk("stalled_jmp_instr", s_instr, word(32'h3008));
    stallF = 1'b0; jmp = 1'b0;
    req_q.push_back(32'h300C);
    tick();
    tick();
    chk("after_stalled_jmp_req", 32'(s_req), 32'd1);

    // Priority: jr beats beq, then jmp beats beq
    out_q.push_back(32'h300C);
    stallF = 1'b1;
    tick();
    stallF = 1'b0; jr = 1'b1; jrTarget = 32'h5000; beq = 1'b1; beqTarget = 32'h6000;
    req_q.push_back(32'h5000);
    tick();
    jr = 1'b0; beq = 1'b0;
    tick();
    chk("prio_jr_req", 32'(s_req), 32'd1);
    out_q.push_back(32'h5000);
    stallF = 1'b1;
    tick();
    stallF = 1'b0; jmp = 1'b1; jmpTarget = 32'h4400; beq = 1'b1;
    req_q.push_back(32'h4400);
    tick();
    jmp = 1'b0; beq = 1'b0;
    tick();
    chk("prio_jmp_req", 32'(s_req), 32'd1);
    reset = 1'b1;
    tick();
    tick();

    // Redirect during WAIT with 3-cycle memory
    lat = 3;
    reset = 1'b0;
    req_q.push_back(32'h3000); out_q.push_back(32'h3000);
    for (int i = 0; i < 4; i++) tick();
    chk("lat3_valid", 32'(s_valid), 32'd1);
    req_q.push_back(32'h3004);
    tick();
    jmp = 1'b1; jmpTarget = 32'h4000;
    tick();
    jmp = 1'b0;
    tick();
    tick();
    chk("drain_discard_valid", 32'(s_valid), 32'd0);
    chk("drain_no_req", 32'(s_req), 32'd0);
    // Redirect taken in ISSUE: the 0x4000 request still goes out and is drained
    req_q.push_back(32'h4000);
    beq = 1'b1; beqTarget = 32'hFFFF_FFFC;
    tick();
    chk("redirect_req", 32'(s_req), 32'd1);
    beq = 1'b0;
    tick();
    tick();
    tick();
    req_q.push_back(32'hFFFF_FFFC); out_q.push_back(32'hFFFF_FFFC);
    tick();
    tick();
    tick();
    tick();
    chk("wrap_valid", 32'(s_valid), 32'd1);
    chk("wrap_pcplus", s_pcplus, 32'd0);
    req_q.push_back(32'h0);
    tick();
    chk("wrap_req", 32'(s_req), 32'd1);

    // Reset mid-WAIT
    reset = 1'b1;
    tick();
    chk("rst_wait_req", 32'(s_req), 32'd0);
    chk("rst_wait_valid", 32'(s_valid), 32'd0);
    chk("rst_wait_instr", s_instr, 32'd0);
    chk("rst_wait_pcplus", s_pcplus, 32'd0);
    tick();
    lat = 1;
    reset = 1'b0;
    req_q.push_back(32'h3000); out_q.push_back(32'h3000);
    tick();
    chk("post_rst_req", 32'(s_req), 32'd1);
    tick();
    chk("post_rst_valid", 32'(s_valid), 32'd1);
    reset = 1'b1;
    tick();

    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("out_q_drained", 32'(out_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
